// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared state encoding and constants for the MNIST core sequencer.
package core_seq_pkg;
    typedef enum logic [2:0] {IDLE, CORE_RST, STREAM, WAIT, RESULT} state_t;
    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CONT = 1'b1;
    localparam logic [3:0] ERR_DIGIT = 4'hF;
endpackage

// File: rtl/core_sequencer_seq_timer.sv
// seq_timer: loadable down-counter; done is high once the count has reached zero.
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign done = (cnt_q == '0);
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: feeds NUM_PIXELS pixels per image to the MNIST core and returns its digit.
// Define CORE_SEQ_TIMEOUT_EN to add a WAIT watchdog that reports ERR_DIGIT with res_error.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_PIXELS = 784,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_pixel,
    output logic                   core_rst,
    output logic                   core_i_valid,
    output logic [DATA_WIDTH-1:0]  core_pixel,
    input  logic                   core_o_valid,
    input  logic [3:0]             core_digit,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [3:0]             res_digit,
    output logic                   res_error,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count
);
`ifdef CORE_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int PW = $clog2(NUM_PIXELS);
    localparam int TMAX = (TO_EN && TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
    localparam int TW = $clog2(TMAX) + 1;

    state_t state_q, state_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [DATA_WIDTH-1:0] core_pixel_q, core_pixel_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic [3:0] res_digit_q, res_digit_d;
    logic mode_q, mode_d, rec_q, rec_d, res_error_q, res_error_d;
    logic core_rst_q, core_i_valid_q, res_valid_q;
    logic s_hs, t_load, t_en, t_done, timeout;
    logic [TW-1:0] t_val;

    assign s_hs = s_valid && s_ready;
    assign t_en = (state_q == CORE_RST) || (state_q == WAIT);
    assign t_load = (state_d != state_q) && (state_d == CORE_RST || (TO_EN && state_d == WAIT));
    assign t_val = (state_d == WAIT) ? TW'(TIMEOUT_CYCLES - 1) : TW'(RST_CYCLES - 1);
    assign timeout = TO_EN && t_done;

    seq_timer #(.W(TW)) u_timer (
        .clk(clk), .rst_n(rst_n), .load(t_load), .load_val(t_val), .en(t_en), .done(t_done)
    );

    always_comb begin
        state_d = state_q;
        pix_cnt_d = pix_cnt_q;
        mode_d = mode_q;
        rec_d = rec_q;
        res_digit_d = res_digit_q;
        res_error_d = res_error_q;
        frame_count_d = frame_count_q;
        core_pixel_d = s_hs ? s_pixel : core_pixel_q;
        case (state_q)
            IDLE: if (start) begin
                mode_d = mode;
                state_d = CORE_RST;
            end
            // rec_q marks the post-timeout reset pass, which may return to IDLE
            CORE_RST: if (t_done) begin
                state_d = (rec_q && mode_q == MODE_SINGLE) ? IDLE : STREAM;
                pix_cnt_d = '0;
                rec_d = 1'b0;
            end
            STREAM: if (s_hs) begin
                pix_cnt_d = pix_cnt_q + PW'(1);
                state_d = (pix_cnt_q == PW'(NUM_PIXELS - 1)) ? WAIT : STREAM;
            end
            WAIT: if (core_o_valid || timeout) begin
                res_digit_d = core_o_valid ? core_digit : ERR_DIGIT;
                res_error_d = !core_o_valid;
                state_d = RESULT;
            end
            RESULT: if (res_ready) begin
                mode_d = mode;
                frame_count_d = frame_count_q + FRAME_CNT_W'(1);
                res_error_d = 1'b0;
                rec_d = res_error_q;
                pix_cnt_d = '0;
                state_d = res_error_q ? CORE_RST : (mode == MODE_CONT) ? STREAM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pix_cnt_q <= '0;
            mode_q <= MODE_SINGLE;
            rec_q <= 1'b0;
            res_digit_q <= '0;
            res_error_q <= 1'b0;
            frame_count_q <= '0;
            core_pixel_q <= '0;
            core_rst_q <= 1'b1;
            core_i_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_cnt_q <= pix_cnt_d;
            mode_q <= mode_d;
            rec_q <= rec_d;
            res_digit_q <= res_digit_d;
            res_error_q <= res_error_d;
            frame_count_q <= frame_count_d;
            core_pixel_q <= core_pixel_d;
            core_rst_q <= (state_d == CORE_RST);
            core_i_valid_q <= s_hs;
            res_valid_q <= (state_d == RESULT);
        end
    end

    assign s_ready = (state_q == STREAM);
    assign busy = (state_q != IDLE);
    assign core_rst = core_rst_q;
    assign core_i_valid = core_i_valid_q;
    assign core_pixel = core_pixel_q;
    assign res_valid = res_valid_q;
    assign res_digit = res_digit_q;
    assign res_error = TO_EN ? res_error_q : 1'b0;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed scoreboard bench for core_sequencer (pixel and result queues).
module tb_core_sequencer;
    localparam int DW = 24;
    localparam int NP = 784;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, mode = 1'b0, s_valid = 1'b0;
    logic core_o_valid = 1'b0, res_ready = 1'b0;
    logic [DW-1:0] s_pixel = '0;
    logic [3:0] core_digit = '0;
    logic s_ready, core_rst, core_i_valid, res_valid, res_error, busy;
    logic [DW-1:0] core_pixel;
    logic [3:0] res_digit;
    logic [15:0] frame_count;
    int n_chk = 0, n_fail = 0, n_iv = 0, n_crst = 0, n_rise = 0;
    logic crst_prev = 1'b1;
    logic [DW-1:0] exp_px[$];
    logic [3:0] exp_res[$];

    core_sequencer #(
        .DATA_WIDTH(DW), .NUM_PIXELS(NP), .RST_CYCLES(2), .TIMEOUT_CYCLES(16), .FRAME_CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .core_rst(core_rst), .core_i_valid(core_i_valid), .core_pixel(core_pixel),
        .core_o_valid(core_o_valid), .core_digit(core_digit),
        .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit), .res_error(res_error),
        .busy(busy), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic hs;
        logic [DW-1:0] px;
        hs = s_valid && s_ready;
        px = s_pixel;
        @(posedge clk);
        #1;
        if (hs) exp_px.push_back(px);
        if (core_rst) n_crst++;
        if (core_rst && !crst_prev) n_rise++;
        crst_prev = core_rst;
        if (core_i_valid) begin
            n_iv++;
            if (exp_px.size() == 0) chk("core_i_valid_spurious", 32'(core_i_valid), 0);
            else chk("core_pixel", 32'(core_pixel), 32'(exp_px.pop_front()));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_px.delete();
        exp_res.delete();
        chk("reset_outputs", 32'({core_rst, core_i_valid, s_ready, res_valid, res_error, busy, res_digit}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}));
        chk("reset_core_pixel", 32'(core_pixel), 0);
        chk("reset_frame_count", 32'(frame_count), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("core_rst_released", 32'(core_rst), 0);
        n_rise = 0;
    endtask

    task automatic go(input logic m);
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int pct, input int n);
        int acc = 0;
        int guard = 0;
        while (acc < n && guard < 20000) begin
            s_valid = ($urandom_range(99) >= 32'(pct));
            s_pixel = DW'($urandom);
            if (s_valid && s_ready) acc++;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        chk("stream_accepted", 32'(acc), 32'(n));
    endtask

    task automatic send_digit(input logic [3:0] d);
        tick();
        tick();
        core_digit = d;
        core_o_valid = 1'b1;
        exp_res.push_back(d);
        tick();
        core_o_valid = 1'b0;
        core_digit = '0;
    endtask

    task automatic take_result(input int hold, input logic err);
        int g = 0;
        int iv0;
        logic stable = 1'b1;
        logic [3:0] e;
        while (!res_valid && g < 5000) begin
            tick();
            g++;
        end
        chk("res_valid_seen", 32'(res_valid), 1);
        e = exp_res.pop_front();
        chk("res_digit", 32'(res_digit), 32'(e));
        chk("res_error", 32'(res_error), 32'(err));
        iv0 = n_iv;
        for (int i = 0; i < hold; i++) begin
            tick();
            stable &= (res_digit === e) && res_valid && !s_ready;
        end
        if (hold > 0) begin
            chk("res_hold_stable", 32'(stable), 1);
            chk("res_hold_no_pixels", 32'(n_iv), 32'(iv0));
        end
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        chk("res_valid_cleared", 32'(res_valid), 0);
    endtask

    initial begin
        #2;
        do_reset();
        core_o_valid = 1'b1;
        core_digit = 4'h4;
        tick();
        core_o_valid = 1'b0;
        tick();
        chk("o_valid_ignored_idle", 32'(res_valid), 0);

        // single image, no bubbles, result held 20 cycles
        n_crst = 0;
        n_iv = 0;
        go(1'b0);
        stream(0, NP);
        chk("core_rst_cycles", 32'(n_crst), 2);
        chk("iv_count_single", 32'(n_iv), NP);
        chk("s_ready_after_last", 32'(s_ready), 0);
        chk("busy_in_wait", 32'(busy), 1);
        send_digit(4'h7);
        take_result(20, 1'b0);
        chk("frame_count_1", 32'(frame_count), 1);
        chk("idle_after_single", 32'(busy), 0);
        tick();
        chk("start_ignored_in_result", 32'(busy), 0);

        // 50% upstream bubbles
        n_iv = 0;
        go(1'b0);
        stream(50, NP);
        chk("iv_count_bubbles", 32'(n_iv), NP);
        chk("px_queue_drained", 32'(exp_px.size()), 0);
        send_digit(4'h2);
        take_result(0, 1'b0);
        chk("frame_count_2", 32'(frame_count), 2);

        // continuous mode, three images
        do_reset();
        go(1'b1);
        stream(30, NP);
        send_digit(4'h3);
        take_result(0, 1'b0);
        stream(30, NP);
        send_digit(4'h5);
        take_result(0, 1'b0);
        stream(30, NP);
        send_digit(4'h9);
        mode = 1'b0;
        take_result(0, 1'b0);
        chk("frame_count_cont", 32'(frame_count), 3);
        chk("core_rst_pulses_cont", 32'(n_rise), 1);
        chk("idle_after_cont", 32'(busy), 0);

        // reset at pixel 400, then a full image
        go(1'b0);
        stream(0, 400);
        do_reset();
        n_iv = 0;
        n_crst = 0;
        go(1'b0);
        stream(0, NP);
        chk("iv_count_after_abort", 32'(n_iv), NP);
        chk("core_rst_cycles_after_abort", 32'(n_crst), 2);
        send_digit(4'h1);
        take_result(0, 1'b0);
        chk("frame_count_after_abort", 32'(frame_count), 1);

`ifdef CORE_SEQ_TIMEOUT_EN
        begin
            int g = 0;
            go(1'b0);
            stream(0, NP);
            while (!res_valid && g < 100) begin
                tick();
                g++;
            end
            chk("timeout_wait_cycles", 32'(g), 16);
            exp_res.push_back(4'hF);
            n_crst = 0;
            take_result(0, 1'b1);
            for (int i = 0; i < 4; i++) tick();
            chk("timeout_core_rst_cycles", 32'(n_crst), 2);
            chk("idle_after_timeout", 32'(busy), 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
